// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter fed by a FIFO. Accepted bytes are queued and sent as
//   frames: one start bit (0), pDataBits data bits LSB first, an optional
//   parity bit, and one or two stop bits (1). Baud divisor, stop-bit count
//   and parity mode are latched when a frame starts. Back-to-back frames are
//   sent with no idle gap.
//
//   Optional feature: define UART_TX_PARITY_EN to build parity support.
//   Without it the parity input is ignored and every frame is no-parity.
//
// Ports
//   clk     in   single clock, all state on the rising edge
//   rst     in   asynchronous active-low reset
//   div     in   clk ticks per bit (0 and 1 both mean one tick)
//   stop2   in   1 = two stop bits, 0 = one
//   parity  in   00 none, 01 even, 10 odd, 11 none
//   stb     in   write request; byte accepted when stb && ready
//   data    in   write byte; bits above pDataBits-1 ignored
//   ready   out  FIFO not full
//   level   out  entries currently stored
//   busy    out  frame in progress or FIFO non-empty
//   tx      out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int pDataBits  = 8,
   parameter int pFifoDepth = 16,
   parameter int pDivWidth  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [pDivWidth-1:0]          div,
   input  logic                          stop2,
   input  logic [1:0]                    parity,
   input  logic                          stb,
   input  logic [7:0]                    data,
   output logic                          ready,
   output logic [$clog2(pFifoDepth):0]   level,
   output logic                          busy,
   output logic                          tx
);

   localparam int AW = $clog2(pFifoDepth);
   localparam int BW = $clog2(pDataBits);
   localparam logic [BW-1:0] LAST_BIT = BW'(pDataBits - 1);
   localparam logic [pDivWidth-1:0] DIV_ONE = {{(pDivWidth-1){1'b0}}, 1'b1};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   // FIFO storage and bookkeeping
   logic [pDataBits-1:0] mem [pFifoDepth];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;

   // Frame engine
   logic [2:0]           state;
   logic [pDivWidth-1:0] baud_cnt;
   logic [pDivWidth-1:0] div_q;
   logic [BW-1:0]        bit_cnt;
   logic [pDataBits-1:0] shreg;
   logic                 stop2_q;
   logic                 stop_more;   // another stop bit follows the current one

`ifdef UART_TX_PARITY_EN
   logic                 par_en_q;
   logic                 par_bit_q;
   logic                 unused_in;
   assign unused_in = ^data;
`else
   logic                 unused_in;
   assign unused_in = ^{parity, data};
`endif

   logic                 push;
   logic                 pop;
   logic                 empty;
   logic                 bit_done;
   logic                 last_stop;
   logic [pDivWidth-1:0] div_eff;
   logic [pDataBits-1:0] head;

   assign empty     = (level == '0);
   assign ready     = (level != (AW+1)'(pFifoDepth));
   assign busy      = (state != S_IDLE) || !empty;
   assign push      = stb && ready;
   assign bit_done  = (baud_cnt == '0);
   assign last_stop = (state == S_STOP) && bit_done && !stop_more;
   // A new frame starts from Idle, or straight out of the final stop bit so
   // consecutive frames abut with no idle gap.
   assign pop       = !empty && ((state == S_IDLE) || last_stop);
   assign div_eff   = (div > DIV_ONE) ? div : DIV_ONE;
   assign head      = mem[rd_ptr];

   // NOTE: storage has no reset; level and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data[pDataBits-1:0];
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // tx is registered from the next-state decision, so the first start-bit
   // cycle appears one clk after the pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         div_q     <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         stop2_q   <= 1'b0;
         stop_more <= 1'b0;
         tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else if (pop) begin
         state     <= S_START;
         baud_cnt  <= div_eff - 1'b1;
         div_q     <= div_eff;
         stop2_q   <= stop2;
         shreg     <= head;
         bit_cnt   <= '0;
         tx        <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= parity[0] ^ parity[1];
         par_bit_q <= (^head) ^ parity[1];
`endif
      end else begin
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
            end
            S_START: begin
               if (bit_done) begin
                  state    <= S_DATA;
                  baud_cnt <= div_q - 1'b1;
                  tx       <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  baud_cnt <= div_q - 1'b1;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     if (par_en_q) begin
                        state <= S_PARITY;
                        tx    <= par_bit_q;
                     end else begin
                        state     <= S_STOP;
                        tx        <= 1'b1;
                        stop_more <= stop2_q;
                     end
`else
                     state     <= S_STOP;
                     tx        <= 1'b1;
                     stop_more <= stop2_q;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_done) begin
                  state     <= S_STOP;
                  baud_cnt  <= div_q - 1'b1;
                  tx        <= 1'b1;
                  stop_more <= stop2_q;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif
            S_STOP: begin
               tx <= 1'b1;
               if (bit_done) begin
                  if (stop_more) begin
                     stop_more <= 1'b0;
                     baud_cnt  <= div_q - 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo (default parameters). Each accepted
//   write pushes the expected frame onto a scoreboard; a line monitor pops it
//   when a start bit appears and compares every tx cycle of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] div = 16'd4;
   logic          stop2 = 1'b0;
   logic [1:0]    parity = 2'b00;
   logic          stb = 1'b0;
   logic [7:0]    data = 8'h00;
   logic          ready;
   logic [LW-1:0] level;
   logic          busy;
   logic          tx;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .pDataBits (8),
      .pFifoDepth(DEPTH),
      .pDivWidth (DW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .div   (div),
      .stop2 (stop2),
      .parity(parity),
      .stb   (stb),
      .data  (data),
      .ready (ready),
      .level (level),
      .busy  (busy),
      .tx    (tx)
   );

   typedef struct {
      logic [7:0] data;
      int         d;
      bit         s2;
      bit         pp;
      bit         pbit;
   } frame_t;

   frame_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic frame_t mk(input logic [7:0] b, input int dv, input bit s2,
                                 input logic [1:0] par);
      frame_t f;
      f.data = b;
      f.d    = (dv <= 1) ? 1 : dv;
      f.s2   = s2;
      f.pp   = PAR_EN && (par == 2'b01 || par == 2'b10);
      f.pbit = (^b) ^ (par == 2'b10);
      return f;
   endfunction

   // Drive one write for a single clock; record it only if it must be accepted.
   task automatic write_byte(input logic [7:0] b, input bit accept);
      data = b;
      stb  = 1'b1;
      @(posedge clk);
      #1;
      stb = 1'b0;
      if (accept) sb.push_back(mk(b, int'(div), stop2, parity));
   endtask

   // ---------------- line monitor ----------------
   bit         mon_active = 1'b0;
   bit         gap_chk = 1'b0;
   frame_t     cur;
   int         mon_cyc, bad, flen, idx;
   logic [7:0] dec;
   logic       e;

   always @(negedge clk) begin
      if (!rst) begin
         mon_active = 1'b0;
         gap_chk    = 1'b0;
      end else begin
         if (gap_chk) begin
            check("no_gap", tx, 0);
            gap_chk = 1'b0;
         end
         if (!mon_active && tx == 1'b0) begin
            if (sb.size() == 0) begin
               check("unexpected_frame", sb.size(), 1);
            end else begin
               cur        = sb.pop_front();
               mon_active = 1'b1;
               mon_cyc    = 0;
               bad        = 0;
               dec        = '0;
               flen       = cur.d * (9 + int'(cur.pp) + (cur.s2 ? 2 : 1));
            end
         end
         if (mon_active) begin
            idx = mon_cyc / cur.d;
            if (idx == 0)                  e = 1'b0;
            else if (idx <= 8)             e = cur.data[idx-1];
            else if (cur.pp && idx == 9)   e = cur.pbit;
            else                           e = 1'b1;
            if (tx !== e) bad++;
            if (idx >= 1 && idx <= 8 && (mon_cyc % cur.d) == cur.d / 2) dec[idx-1] = tx;
            mon_cyc++;
            if (mon_cyc == flen) begin
               check("frame_bits", bad, 0);
               check("frame_data", dec, cur.data);
               mon_active = 1'b0;
               if (sb.size() > 0) gap_chk = 1'b1;
            end
         end
      end
   end

   task automatic wait_start(input int budget);
      int n = 0;
      while (!mon_active && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("start_timeout", mon_active, 1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || mon_active) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", (sb.size() != 0 || mon_active), 0);
      @(posedge clk);
      #1;
      check("busy_idle", busy, 0);
      check("tx_idle", tx, 1);
      check("level_idle", level, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;

      // Reset state, with a write request held during reset
      stb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", tx, 1);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_level", level, 0);
      stb = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame: 0x55 at 4 clks per bit, level/start timing
      div = 16'd4; stop2 = 1'b0; parity = 2'b00;
      write_byte(8'h55, 1'b1);
      check("level_after_write", level, 1);
      check("busy_after_write", busy, 1);
      check("tx_before_pop", tx, 1);
      @(posedge clk);
      #1;
      check("tx_start_bit", tx, 0);
      check("level_after_pop", level, 0);
      drain(200);

      // Divisor 0 and 1 both mean one clk per bit
      div = 16'd0;
      write_byte(8'hA3, 1'b1);
      div = 16'd1;
      write_byte(8'h5C, 1'b1);
      drain(100);

      // Parity modes (honoured only with parity support built in)
      div = 16'd2;
      parity = 2'b01;
      write_byte(8'h83, 1'b1);
      drain(100);
      parity = 2'b10;
      write_byte(8'h83, 1'b1);
      drain(100);
      parity = 2'b11;
      write_byte(8'h0F, 1'b1);
      drain(100);
      parity = 2'b00;

      // Two stop bits, back-to-back frames
      div = 16'd3; stop2 = 1'b1;
      write_byte(8'hFF, 1'b1);
      write_byte(8'h00, 1'b1);
      drain(200);
      stop2 = 1'b0;

      // Divisor change mid-frame only affects the next frame
      div = 16'd4;
      write_byte(8'hA5, 1'b1);
      wait_start(50);
      div = 16'd10;
      write_byte(8'h3C, 1'b1);
      drain(400);

      // Fill: 17 writes accepted (one in flight + 16 stored), 18th dropped
      div = 16'd8;
      for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i), 1'b1);
      check("level_full", level, 16);
      check("ready_full", ready, 0);
      write_byte(8'hEE, 1'b0);
      check("level_after_drop", level, 16);
      drain(2000);

      // Reset in the middle of data bit 3 with bytes queued
      div = 16'd4;
      write_byte(8'h11, 1'b1);
      write_byte(8'h22, 1'b1);
      write_byte(8'h33, 1'b1);
      wait_start(50);
      repeat (17) @(posedge clk);
      #1;
      check("tx_low_before_reset", tx, 0);
      rst = 1'b0;
      #1;
      check("reset_tx", tx, 1);
      check("reset_level", level, 0);
      check("reset_busy", busy, 0);
      check("reset_ready", ready, 1);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx == 1'b0) lows++;
      end
      check("idle_after_reset", lows, 0);
      check("busy_after_reset", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
